column_cursor_encoder: RTL and testbench

- Player-side column selector for Connect4: holds a cursor (column index 0..6), moved by left/right button pulses, and skips columns the board reports full.
- Encodes the cursor as a one-hot 7-bit column code (bit i = column i) for the LEDs and the board's column-decode input.
- Issues a drop request with a valid/done handshake to the board controller.
- Sits between the debounced button logic and the board/game controller.

---
 rtl/column_cursor_encoder.sv | 122 ++++++++++++
 tb/tb_column_cursor_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/column_cursor_encoder.sv
// Connect4 column cursor: left/right seeking past full columns, one-hot column code,
// and a valid/done drop handshake towards the board controller.
module column_cursor_encoder #(
    parameter int NUM_COLS  = 7,
    parameter int IDX_W     = 3,
    parameter int START_COL = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                move_left,
    input  logic                move_right,
    input  logic                drop_req,
    input  logic [NUM_COLS-1:0] col_full,
    input  logic                turn_done,
    output logic [IDX_W-1:0]    column_index,
    output logic [NUM_COLS-1:0] column_onehot,
    output logic                drop_valid,
    output logic                busy,
    output logic                no_moves
);

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        DROP
    } state_t;

    localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(NUM_COLS - 1);
    localparam logic [IDX_W-1:0] FIRST_COL = '0;
    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(START_COL);
    // A seek may take at most NUM_COLS-1 steps; this is the count before the last one.
    localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(NUM_COLS - 2);

    state_t           state;
    logic             dir_right;
    logic [IDX_W-1:0] step_cnt;
    logic [IDX_W-1:0] seek_next;
    logic             all_full;
    logic             single_move;

    function automatic logic [IDX_W-1:0] next_col(input logic [IDX_W-1:0] idx,
                                                  input logic right);
        logic [IDX_W-1:0] r;
        if (right) r = (idx == LAST_COL) ? FIRST_COL : idx + 1'b1;
        else       r = (idx == FIRST_COL) ? LAST_COL : idx - 1'b1;
        return r;
    endfunction

    function automatic logic [NUM_COLS-1:0] onehot_of(input logic [IDX_W-1:0] idx);
        return {{(NUM_COLS-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign seek_next   = next_col(column_index, dir_right);
    assign all_full    = &col_full;
    assign single_move = move_left ^ move_right;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            column_index  <= START_IDX;
            column_onehot <= onehot_of(START_IDX);
            drop_valid    <= 1'b0;
            busy          <= 1'b0;
            no_moves      <= 1'b0;
            dir_right     <= 1'b1;
            step_cnt      <= '0;
        end else begin
            no_moves <= all_full;
            case (state)
                IDLE: begin
                    // A drop request owns the cycle even when it cannot be honoured.
                    if (drop_req) begin
                        if (!col_full[column_index] && !no_moves) begin
                            state      <= DROP;
                            drop_valid <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end else if (single_move) begin
                        if (!no_moves) begin
                            state     <= SEEK;
                            busy      <= 1'b1;
                            dir_right <= move_right;
                            step_cnt  <= '0;
                        end
                    end else if (!move_left && col_full[column_index] && !no_moves) begin
                        state     <= SEEK;
                        busy      <= 1'b1;
                        dir_right <= 1'b1;
                        step_cnt  <= '0;
                    end
                end
                SEEK: begin
                    if (all_full) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        column_index  <= seek_next;
                        column_onehot <= onehot_of(seek_next);
                        step_cnt      <= step_cnt + 1'b1;
                        if (!col_full[seek_next] || step_cnt == LAST_STEP) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (turn_done) begin
                        state      <= IDLE;
                        drop_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    drop_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_column_cursor_encoder.sv
// Bench for column_cursor_encoder: directed vector table, a reset-mid-seek sequence,
// and randomized traffic checked against a behavioural model of the cursor rules.
module tb_column_cursor_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       move_left;
    logic       move_right;
    logic       drop_req;
    logic [6:0] col_full;
    logic       turn_done;
    logic [2:0] column_index;
    logic [6:0] column_onehot;
    logic       drop_valid;
    logic       busy;
    logic       no_moves;

    int n_checks = 0;
    int n_fail   = 0;

    column_cursor_encoder #(.NUM_COLS(7), .IDX_W(3), .START_COL(3)) dut (
        .clk(clk),
        .rst(rst),
        .move_left(move_left),
        .move_right(move_right),
        .drop_req(drop_req),
        .col_full(col_full),
        .turn_done(turn_done),
        .column_index(column_index),
        .column_onehot(column_onehot),
        .drop_valid(drop_valid),
        .busy(busy),
        .no_moves(no_moves)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst, ml, mr, dr, td;
        logic [6:0] cf;
        int         idx;
        bit         dv, bsy, nm;
    } vec_t;

    vec_t vecs[$];

    localparam int M_IDLE = 0;
    localparam int M_SEEK = 1;
    localparam int M_DROP = 2;

    int m_mode, m_idx, m_steps;
    bit m_dv, m_nm, m_right;

    task automatic add(input bit r, ml, mr, dr, td, input logic [6:0] cf,
                       input int idx, input bit dv, bsy, nm);
        vec_t v;
        v.rst = r; v.ml = ml; v.mr = mr; v.dr = dr; v.td = td; v.cf = cf;
        v.idx = idx; v.dv = dv; v.bsy = bsy; v.nm = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit r, ml, mr, dr, td, input logic [6:0] cf);
        rst = r; move_left = ml; move_right = mr; drop_req = dr; turn_done = td; col_full = cf;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int eidx, input bit edv, ebsy, enm);
        int oh;
        oh = 1 << eidx;
        chk({tag, " index"}, int'(column_index), eidx);
        chk({tag, " onehot"}, int'(column_onehot), oh);
        chk({tag, " drop_valid"}, int'(drop_valid), int'(edv));
        chk({tag, " busy"}, int'(busy), int'(ebsy));
        chk({tag, " no_moves"}, int'(no_moves), int'(enm));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: cursor behaviour written from the selector's rules, one clock at a time.
    task automatic model_step(input bit r, ml, mr, dr, td, input logic [6:0] cf);
        bit old_nm;
        if (r) begin
            m_mode = M_IDLE; m_idx = 3; m_dv = 0; m_nm = 0; m_right = 1; m_steps = 0;
            return;
        end
        old_nm = m_nm;
        m_nm = (cf == 7'h7F);
        case (m_mode)
            M_IDLE: begin
                if (dr) begin
                    if (!cf[m_idx] && !old_nm) begin
                        m_mode = M_DROP; m_dv = 1;
                    end
                end else if (ml != mr) begin
                    if (!old_nm) begin
                        m_mode = M_SEEK; m_right = mr; m_steps = 0;
                    end
                end else if (!ml && cf[m_idx] && !old_nm) begin
                    m_mode = M_SEEK; m_right = 1; m_steps = 0;
                end
            end
            M_SEEK: begin
                if (cf == 7'h7F) begin
                    m_mode = M_IDLE;
                end else begin
                    m_idx = m_right ? (m_idx + 1) % 7 : (m_idx + 6) % 7;
                    m_steps++;
                    if (!cf[m_idx] || m_steps >= 6) m_mode = M_IDLE;
                end
            end
            default: begin
                if (td) begin
                    m_mode = M_IDLE; m_dv = 0;
                end
            end
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         r, ml, mr, dr, td;
        logic [6:0] cf;
        drive(1, 0, 0, 0, 0, 7'h00);

        //   rst ml mr dr td  col_full  idx dv busy nm
        add(1, 0, 0, 0, 0, 7'h00, 3, 0, 0, 0);
        add(0, 0, 0, 0, 0, 7'h00, 3, 0, 0, 0);
        add(0, 0, 1, 0, 0, 7'h00, 3, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h00, 4, 0, 0, 0);
        add(0, 1, 0, 0, 0, 7'h00, 4, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h00, 3, 0, 0, 0);
        add(0, 0, 1, 0, 0, 7'h00, 3, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h00, 4, 0, 0, 0);
        add(0, 0, 1, 0, 0, 7'h20, 4, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h20, 5, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h20, 6, 0, 0, 0);
        add(0, 0, 1, 0, 0, 7'h00, 6, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h00, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 7'h00, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h00, 6, 0, 0, 0);
        add(0, 0, 1, 0, 0, 7'h00, 6, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h00, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 7'h00, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 7'h00, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 7'h00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 7'h00, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 7'h01, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 7'h00, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 7'h00, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 7'h00, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 7'h00, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h00, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 7'h00, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h00, 2, 0, 0, 0);
        add(0, 0, 0, 0, 0, 7'h0C, 2, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h0C, 3, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7'h0C, 4, 0, 0, 0);
        add(0, 0, 0, 0, 0, 7'h7F, 4, 0, 1, 1);
        add(0, 0, 0, 0, 0, 7'h7F, 4, 0, 0, 1);
        add(0, 0, 1, 0, 0, 7'h7F, 4, 0, 0, 1);
        add(0, 0, 0, 1, 0, 7'h7F, 4, 0, 0, 1);
        add(0, 1, 0, 0, 0, 7'h7F, 4, 0, 0, 1);
        add(0, 0, 0, 0, 0, 7'h00, 4, 0, 0, 0);
        add(0, 1, 0, 0, 0, 7'h00, 4, 0, 1, 0);
        add(1, 0, 0, 0, 0, 7'h00, 3, 0, 0, 0);
        add(0, 0, 0, 1, 0, 7'h00, 3, 1, 1, 0);
        add(1, 0, 0, 0, 0, 7'h00, 3, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ml, vecs[i].mr, vecs[i].dr, vecs[i].td, vecs[i].cf);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].idx, vecs[i].dv, vecs[i].bsy, vecs[i].nm);
        end

        // Reset lands while a multi-column seek is still walking.
        drive(0, 0, 1, 0, 0, 7'h70);
        tick();
        check_all("rstseek_a", 3, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 7'h70);
        tick();
        check_all("rstseek_b", 4, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 7'h70);
        tick();
        check_all("rstseek_c", 3, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 7'h00);
        tick();
        check_all("rstseek_d", 3, 0, 0, 0);

        // Randomized traffic against the model.
        cf = 7'h00;
        drive(1, 0, 0, 0, 0, cf);
        tick();
        model_step(1, 0, 0, 0, 0, cf);
        check_all("rnd_reset", m_idx, m_dv, m_mode != M_IDLE, m_nm);
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 99) == 0);
            ml = ($urandom_range(0, 3) == 0);
            mr = ($urandom_range(0, 3) == 0);
            dr = ($urandom_range(0, 5) == 0);
            td = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 9))
                    0:       cf = 7'h7F;
                    1:       cf = 7'h00;
                    2:       cf = 7'($urandom) | 7'($urandom);
                    default: cf = 7'($urandom) & 7'($urandom);
                endcase
            end
            drive(r, ml, mr, dr, td, cf);
            tick();
            model_step(r, ml, mr, dr, td, cf);
            check_all($sformatf("rnd%0d", c), m_idx, m_dv, m_mode != M_IDLE, m_nm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
